// File: rtl/dcache_sa_wb_pkg.sv
// Shared constants for the MEM-stage data cache: LS_op width codes and
// cache controller state encodings.
package dcache_sa_wb_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    DC_IDLE      = 2'd0,
    DC_WRITEBACK = 2'd1,
    DC_REFILL    = 2'd2
  } dc_state_e;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/dcache_sa_wb_if.sv
// CPU-side and memory-side signals of the data cache bundled as one bus.
// The cache takes the slave view; the pipeline/memory environment the master view.
interface dcache_sa_wb_if;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  LS_op;
  logic [31:0] DataOut;
  logic        DStall;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic [31:0] MemData;
  logic        MemAck;

  modport slave (
    input  Addr, WriteData, MemRead, MemWrite, LS_op, MemData, MemAck,
    output DataOut, DStall, MemReq, MemWe, MemAddr, MemWriteData
  );

  modport master (
    output Addr, WriteData, MemRead, MemWrite, LS_op, MemData, MemAck,
    input  DataOut, DStall, MemReq, MemWe, MemAddr, MemWriteData
  );
endinterface

// File: rtl/dcache_sa_wb_ls_align.sv
// Load extraction/extension and SB/SH merge for one 32-bit cache word.
// Unknown LS_op codes fall back to full-word load/store.
module dcache_ls_align
  import dcache_sa_wb_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_byte,
  input  logic [2:0]  i_ls_op,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_word >> {i_byte, 3'b000});
  assign w_half = 16'(i_word >> {i_byte[1], 4'b0000});

  always_comb begin
    case (i_ls_op)
      LS_B:    o_load = sext8(w_byte);
      LS_BU:   o_load = {24'd0, w_byte};
      LS_H:    o_load = sext16(w_half);
      LS_HU:   o_load = {16'd0, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    case (i_ls_op)
      LS_B:    o_merged[{i_byte, 3'b000} +: 8]     = i_wdata[7:0];
      LS_H:    o_merged[{i_byte[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/dcache_sa_wb.sv
// Set-associative write-back/write-allocate data cache for the MEM stage,
// with a per-beat req/ack burst interface to data memory.
module dcache_sa_wb
  import dcache_sa_wb_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic           clk,
  input  logic           rst,
  dcache_sa_wb_if.slave  bus
);

  localparam int WB   = $clog2(LINE_WORDS);
  localparam int WBW  = (WB > 0) ? WB : 1;
  localparam int IB   = $clog2(SETS);
  localparam int TB   = 30 - WB - IB;
  localparam int LAST = LINE_WORDS - 1;

  // state        | meaning
  // DC_IDLE      | lookup; hits served combinationally
  // DC_WRITEBACK | streaming dirty victim line out, one beat per ack
  // DC_REFILL    | streaming requested line into the victim way
  dc_state_e        r_state;
  logic [WBW-1:0]   r_beat;
  logic             r_vway;
  logic [IB-1:0]    r_idx;
  logic [TB-1:0]    r_rtag;
  logic [TB-1:0]    r_vtag;
  logic [SETS-1:0]  r_valid [WAYS];
  logic [SETS-1:0]  r_dirty [WAYS];
  logic [SETS-1:0]  r_lru;
  logic [TB-1:0]    r_tag   [WAYS][SETS];
  logic [31:0]      r_data  [WAYS][SETS][LINE_WORDS];

  logic [IB-1:0]    w_idx;
  logic [TB-1:0]    w_tag;
  logic [WBW-1:0]   w_word;
  logic             w_req;
  logic             w_hit;
  logic             w_hit_way;
  logic             w_vic;
  logic             w_idle_hit;
  logic             w_miss;
  logic             w_fill_we;
  logic             w_last;
  logic             w_busy;
  logic [31:0]      w_hit_word;
  logic [31:0]      w_load;
  logic [31:0]      w_merged;

  assign w_idx  = IB'(bus.Addr >> (2 + WB));
  assign w_tag  = TB'(bus.Addr >> (2 + WB + IB));
  assign w_word = WBW'(bus.Addr >> 2) & WBW'(LAST);
  assign w_req  = bus.MemRead | bus.MemWrite;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = 1'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise evict the LRU way.
  always_comb begin
    w_vic = (WAYS == 1) ? 1'b0 : r_lru[w_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][w_idx]) w_vic = 1'(w);
    end
  end

  assign w_hit_word = r_data[w_hit_way][w_idx][w_word];
  assign w_idle_hit = !rst && (r_state == DC_IDLE) && w_req && w_hit;
  assign w_miss     = !rst && (r_state == DC_IDLE) && w_req && !w_hit;
  assign w_busy     = !rst && (r_state != DC_IDLE);
  assign w_fill_we  = w_busy && (r_state == DC_REFILL) && bus.MemAck;
  assign w_last     = (r_beat == WBW'(LAST));

  dcache_ls_align u_align (
    .i_word   (w_hit_word),
    .i_wdata  (bus.WriteData),
    .i_byte   (bus.Addr[1:0]),
    .i_ls_op  (bus.LS_op),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  assign bus.DStall       = w_busy | w_miss;
  assign bus.DataOut      = w_idle_hit ? (bus.MemWrite ? w_merged : w_load) : 32'd0;
  assign bus.MemReq       = w_busy;
  assign bus.MemWe        = w_busy && (r_state == DC_WRITEBACK);
  assign bus.MemAddr      = !w_busy ? 32'd0 :
                            ((32'((r_state == DC_WRITEBACK) ? r_vtag : r_rtag) << (2 + WB + IB))
                             | (32'(r_idx) << (2 + WB)) | (32'(r_beat) << 2));
  assign bus.MemWriteData = bus.MemWe ? r_data[r_vway][r_idx][r_beat] : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DC_IDLE;
      r_beat  <= '0;
      r_vway  <= 1'b0;
      r_idx   <= '0;
      r_rtag  <= '0;
      r_vtag  <= '0;
      r_lru   <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
    end else begin
      case (r_state)
        DC_IDLE: begin
          if (w_idle_hit) begin
            if (bus.MemWrite) r_dirty[w_hit_way][w_idx] <= 1'b1;
            if (WAYS == 2) r_lru[w_idx] <= ~w_hit_way;
          end else if (w_miss) begin
            r_vway  <= w_vic;
            r_idx   <= w_idx;
            r_rtag  <= w_tag;
            r_vtag  <= r_tag[w_vic][w_idx];
            r_beat  <= '0;
            r_state <= (r_valid[w_vic][w_idx] && r_dirty[w_vic][w_idx]) ? DC_WRITEBACK
                                                                        : DC_REFILL;
          end
        end
        DC_WRITEBACK: begin
          if (bus.MemAck) begin
            if (w_last) begin
              r_beat  <= '0;
              r_state <= DC_REFILL;
            end else begin
              r_beat <= r_beat + WBW'(1);
            end
          end
        end
        DC_REFILL: begin
          if (bus.MemAck) begin
            if (w_last) begin
              r_valid[r_vway][r_idx] <= 1'b1;
              r_dirty[r_vway][r_idx] <= 1'b0;
              r_beat                 <= '0;
              r_state                <= DC_IDLE;
            end else begin
              r_beat <= r_beat + WBW'(1);
            end
          end
        end
        default: r_state <= DC_IDLE;
      endcase
    end
  end

  // Line storage carries no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (w_idle_hit && bus.MemWrite) r_data[w_hit_way][w_idx][w_word] <= w_merged;
    if (w_fill_we) begin
      r_data[r_vway][r_idx][r_beat] <= bus.MemData;
      if (w_last) r_tag[r_vway][r_idx] <= r_rtag;
    end
  end

endmodule

// File: tb/tb_dcache_sa_wb.sv
// Directed + random bench for dcache_sa_wb against an architectural memory
// model plus a tag-only MRU-ordered residency model per set.
module tb_dcache_sa_wb;
  import dcache_sa_wb_pkg::*;

  typedef struct {
    bit          we;
    logic [31:0] addr;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_sa_wb_if bus ();

  dcache_sa_wb #(.SETS(16), .WAYS(2), .LINE_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] arch [logic [31:0]];
  logic [31:0] bk   [logic [31:0]];
  bit          dirty_l [logic [31:0]];
  logic [31:0] lru_q [16][$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  function automatic logic [31:0] rd_arch(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rd_bk(input logic [31:0] a);
    return bk.exists(a) ? bk[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] b,
                                      input logic [2:0] op);
    logic [31:0] by, hf;
    by = (w >> (8 * b)) & 32'hFF;
    hf = (w >> (16 * b[1])) & 32'hFFFF;
    case (op)
      3'd0:    return (by >= 128) ? by - 32'd256 : by;
      3'd1:    return (hf >= 32768) ? hf - 32'd65536 : hf;
      3'd4:    return by;
      3'd5:    return hf;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                        input logic [1:0] b, input logic [2:0] op);
    logic [31:0] m;
    case (op)
      3'd0: begin
        m = 32'hFF << (8 * b);
        return (w & ~m) | ((wd & 32'hFF) << (8 * b));
      end
      3'd1: begin
        m = 32'hFFFF << (16 * b[1]);
        return (w & ~m) | ((wd & 32'hFFFF) << (16 * b[1]));
      end
      default: return wd;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) lru_q[i].delete();
    dirty_l.delete();
    arch = bk;
  endtask

  // One CPU access from issue to the hit cycle, acting as the memory too.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] op,
                       input int wait_beat, input int wait_n,
                       output logic [31:0] got, output int stall);
    logic [31:0] line, ev, wa, exp_do;
    int          s, hit_pos, exp_stall, nb, waited;
    bit          req, hit;
    beat_t       eb[$];
    beat_t       bt;
    req = rd | wr;
    line = a & ~32'hF;
    s = int'((a >> 4) & 32'hF);
    hit_pos = -1;
    foreach (lru_q[s][i]) if (lru_q[s][i] == line) hit_pos = i;
    hit = (hit_pos >= 0);
    exp_stall = 0;
    exp_do = 32'd0;
    if (req) begin
      if (!hit) begin
        if (lru_q[s].size() == 2) begin
          ev = lru_q[s].pop_back();
          if (dirty_l.exists(ev) && dirty_l[ev])
            for (int i = 0; i < 4; i++) begin
              bt.we = 1'b1; bt.addr = ev + 32'(4 * i); eb.push_back(bt);
            end
        end
        for (int i = 0; i < 4; i++) begin
          bt.we = 1'b0; bt.addr = line + 32'(4 * i); eb.push_back(bt);
        end
        dirty_l[line] = 1'b0;
        exp_stall = 1 + eb.size() + ((wait_beat >= 0 && wait_beat < eb.size()) ? wait_n : 0);
      end else begin
        lru_q[s].delete(hit_pos);
      end
      lru_q[s].push_front(line);
      wa = a & ~32'h3;
      if (wr) begin
        arch[wa] = merge(rd_arch(wa), wd, a[1:0], op);
        exp_do = arch[wa];
        dirty_l[line] = 1'b1;
      end else begin
        exp_do = ext(rd_arch(wa), a[1:0], op);
      end
    end
    bus.Addr = a; bus.WriteData = wd; bus.LS_op = op;
    bus.MemRead = rd; bus.MemWrite = wr;
    nb = 0; waited = 0; stall = 0;
    forever begin
      #1;
      if (!bus.DStall) break;
      stall++;
      if (stall > 64) begin
        chk("stall_bound", 32'(stall), 32'(exp_stall));
        break;
      end
      if (bus.MemReq) begin
        if (nb >= eb.size()) begin
          chk("extra_beat", 32'(nb), 32'(eb.size()));
          bus.MemAck = 1'b1;
        end else begin
          chk("beat_addr", bus.MemAddr, eb[nb].addr);
          chk("beat_we", 32'(bus.MemWe), 32'(eb[nb].we));
          if (nb == wait_beat && waited < wait_n) begin
            waited++;
            bus.MemAck = 1'b0;
          end else begin
            if (eb[nb].we) begin
              chk("wb_data", bus.MemWriteData, rd_arch(bus.MemAddr));
              bk[bus.MemAddr] = bus.MemWriteData;
            end else begin
              bus.MemData = rd_bk(bus.MemAddr);
            end
            bus.MemAck = 1'b1;
            nb++;
          end
        end
      end
      @(posedge clk);
      @(negedge clk);
      bus.MemAck = 1'b0;
      bus.MemData = 32'd0;
    end
    got = bus.DataOut;
    chk("data_out", got, exp_do);
    chk("stall_cycles", 32'(stall), 32'(exp_stall));
    chk("beat_count", 32'(nb), 32'(eb.size()));
    chk("memreq_idle", 32'(bus.MemReq), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] g;
  int          st;
  int          kind;
  logic [2:0]  rop;
  logic [31:0] ra;
  bit          rrd, rwr;

  initial begin
    rst = 1'b1;
    bus.Addr = 32'h100; bus.WriteData = 32'd0; bus.LS_op = LS_W;
    bus.MemRead = 1'b1; bus.MemWrite = 1'b0;
    bus.MemData = 32'd0; bus.MemAck = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_dstall", 32'(bus.DStall), 32'd0);
    chk("rst_memreq", 32'(bus.MemReq), 32'd0);
    chk("rst_dataout", bus.DataOut, 32'd0);
    chk("rst_memaddr", bus.MemAddr, 32'd0);
    chk("rst_memwe", 32'(bus.MemWe), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.MemRead = 1'b0;

    // Cold miss then hit in the same line
    do_op(1, 0, 32'h100, 0, LS_W, -1, 0, g, st);
    chk("t1_stall", 32'(st), 32'd5);
    do_op(1, 0, 32'h104, 0, LS_W, -1, 0, g, st);
    chk("t1_hit_stall", 32'(st), 32'd0);

    // Load extension
    do_op(0, 1, 32'h100, 32'h8001_7FFF, LS_W, -1, 0, g, st);
    do_op(1, 0, 32'h102, 0, LS_H, -1, 0, g, st);
    chk("t2_lh", g, 32'hFFFF8001);
    do_op(1, 0, 32'h102, 0, LS_HU, -1, 0, g, st);
    chk("t2_lhu", g, 32'h00008001);
    do_op(1, 0, 32'h100, 0, LS_B, -1, 0, g, st);
    chk("t2_lb", g, 32'hFFFFFFFF);
    do_op(1, 0, 32'h101, 0, LS_BU, -1, 0, g, st);
    chk("t2_lbu", g, 32'h0000007F);

    // Byte store merge
    do_op(0, 1, 32'h100, 32'h1122_3344, LS_W, -1, 0, g, st);
    do_op(0, 1, 32'h103, 32'h0000_00AB, LS_B, -1, 0, g, st);
    chk("t3_sb_stall", 32'(st), 32'd0);
    do_op(1, 0, 32'h100, 0, LS_W, -1, 0, g, st);
    chk("t3_lw", g, 32'hAB223344);
    do_op(1, 0, 32'h103, 0, LS_B, -1, 0, g, st);
    chk("t3_lb", g, 32'hFFFFFFAB);

    // Dirty eviction of LRU way
    do_op(1, 0, 32'h200, 0, LS_W, -1, 0, g, st);
    do_op(1, 0, 32'h200, 0, LS_W, -1, 0, g, st);
    do_op(1, 0, 32'h300, 0, LS_W, -1, 0, g, st);
    chk("t4_stall", 32'(st), 32'd9);
    chk("t4_wb_word", rd_bk(32'h100), 32'hAB223344);
    do_op(1, 0, 32'h200, 0, LS_W, -1, 0, g, st);
    chk("t4_200_hit", 32'(st), 32'd0);

    // Ack withheld on refill beat 1
    do_op(1, 0, 32'h100, 0, LS_W, 1, 3, g, st);
    chk("t5_stall", 32'(st), 32'd8);
    chk("t5_data", g, 32'hAB223344);

    // Reset in the middle of a refill
    bus.Addr = 32'h400; bus.LS_op = LS_W; bus.MemRead = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.MemReq) begin
        bus.MemAck = 1'b1;
        bus.MemData = rd_bk(bus.MemAddr);
      end
      @(posedge clk);
      @(negedge clk);
      bus.MemAck = 1'b0;
    end
    #1;
    chk("t6_beat2_addr", bus.MemAddr, 32'h408);
    chk("t6_pre_stall", 32'(bus.DStall), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_memreq", 32'(bus.MemReq), 32'd0);
    chk("t6_rst_dstall", 32'(bus.DStall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.MemRead = 1'b0;
    rst = 1'b0;
    model_reset();
    do_op(1, 0, 32'h100, 0, LS_W, -1, 0, g, st);
    chk("t6_refill_stall", 32'(st), 32'd5);

    // Random traffic over 4 tags x 4 sets
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      ra = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
         | (32'($urandom_range(0, 3)) << 2);
      if (kind < 5) begin
        rrd = 1'b1; rwr = 1'b0;
        case ($urandom_range(0, 7))
          0: rop = 3'd0;
          1: rop = 3'd1;
          2: rop = 3'd2;
          3: rop = 3'd4;
          4: rop = 3'd5;
          5: rop = 3'd3;
          6: rop = 3'd6;
          default: rop = 3'd7;
        endcase
      end else if (kind < 9) begin
        rrd = (kind == 8); rwr = 1'b1;
        case ($urandom_range(0, 3))
          0: rop = 3'd0;
          1: rop = 3'd1;
          2: rop = 3'd2;
          default: rop = 3'd5;
        endcase
      end else begin
        rrd = 1'b0; rwr = 1'b0; rop = 3'd2;
      end
      if (rop == 3'd0 || (rop == 3'd4 && !rwr)) ra = ra | 32'($urandom_range(0, 3));
      else if (rop == 3'd1 || (rop == 3'd5 && !rwr)) ra = ra | (32'($urandom_range(0, 1)) << 1);
      do_op(rrd, rwr, ra, $urandom(), rop, $urandom_range(0, 7), $urandom_range(0, 2), g, st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
